autosa_sdp_wdma_eg: RTL and testbench
=====================================

// Module: autosa_sdp_wdma_eg
// PURPOSE
//  Write-side egress of the SDP DMA engine: the transmit counterpart of the MRDMA read egress.
//  Takes write commands from the command queue and 256-bit result beats from the SDP datapath.
//  Per command, emits one header packet, then the data atoms, as 64-bit DMA write-request packets.
//  Pulses wr_done when the last command of a layer has fully drained.
// PARAMETERS
//  ADDR_W          32  byte address width in command and header
//  SIZE_W          13  atom-count field width (size-1 encoding)
//  ATOM_W          64  DMA atom width
//  ATOMS_PER_BEAT   4  atoms per datapath beat (beat = ATOMS_PER_BEAT*ATOM_W = 256 bits)
// PORTS
//  autosa_core_clk      in   1    clock; one clock domain
//  autosa_core_rst      in   1    reset, synchronous, active-high
//  op_load              in   1    layer start pulse; clears wr_done and sticky status
//  cq2eg_pd             in   46   [31:0] addr, [44:32] atoms-1, [45] cmd_last
//  cq2eg_pvld/prdy      in/out 1  command valid/ready
//  dp2wdma_pd           in   258  [255:0] data, atom0 at LSB; [257:256] valid atoms-1
//  dp2wdma_valid/ready  in/out 1  datapath beat valid/ready
//  dma_wr_req_pd        out  66   [65] type (0 hdr, 1 data); hdr: [31:0] addr, [44:32] size; data: [63:0]
//  dma_wr_req_vld/rdy   out/in 1  DMA write-request valid/ready
//  wr_done              out  1    one-cycle pulse: last atom of cmd_last command accepted by DMA
//  dp2reg_status_wr_err out  1    sticky: beat atom count exceeded remaining command atoms
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, output register empty; cq2eg_prdy=0 and dp2wdma_ready=0 during reset.
//  Handshakes: valid/ready transfer when both high in a cycle.
//   Valid never drops, and payload never changes, until accepted.
//  Output stage is a 2-entry skid register, so dma_wr_req_rdy is never combinationally tied to input readies.
//  FSM:
//   IDLE: cq2eg_prdy=1; on accept, latch addr, rem=size+1 and last -> HDR.
//   HDR: push header packet; on push -> DATA.
//   DATA: pop beats via unpack; push one atom per cycle; rem decrements per pushed atom.
//    rem hits 0 -> IDLE; if last, raise wr_done when that atom leaves the skid stage.
//  Latency: cmd accept -> header valid at output is 2 cycles. Beat accept -> first atom valid is 2 cycles.
//   Sustained throughput is 1 atom/cycle with dma_wr_req_rdy held high.
//  dp2wdma_ready=1 only in DATA when the unpack buffer is empty or its final atom is being consumed.
//   A new beat therefore loads with no bubble.
//  Beat straddling: beats never span commands. If a beat's atoms exceed rem:
//   - excess atoms are dropped and the beat is fully consumed
//   - dp2reg_status_wr_err is set (sticky until op_load or reset)
//  Partial beats (valid atoms < 4): only the counted atoms are sent; the next beat starts at its atom0.
//  size field 13 bits; rem is 14 bits so size=8191 (8192 atoms) does not wrap.
//  Simultaneous events:
//   - op_load in the same cycle as a wr_done event: wr_done still pulses, status clears.
//   - op_load does not abort an in-flight command.
//  Reset mid-command: state, output skid entries and unpack buffer are discarded; no partial packet survives.
//  Output backpressure (dma_wr_req_rdy=0): the FSM stalls, rem holds, and no beat is accepted once the skid is full.
// STRUCTURE
//  Shared package autosa_sdp_wdma_pkg:
//   - PKT_HDR/PKT_DATA constants
//   - hdr/data field offsets
//   - cmd field offsets
//   - FSM state enum {IDLE,HDR,DATA}
//  Sub-module autosa_sdp_wdma_eg_unpack: beat register plus atom index.
//   Presents one atom per pop; reports last-atom using the beat's valid count.
//  The top level holds the FSM, rem/last registers, skid stage, done and error logic.
// TESTING
//  T1: cmd addr=0x1000,size=7 (8 atoms), last=1; 2 full beats, rdy=1
//   -> hdr{0x1000,7}, 8 data atoms in order, one wr_done pulse on atom 8.
//  T2: cmd size=2 (3 atoms); 1 beat with valid atoms-1=3
//   -> 3 atoms sent, atom3 dropped, wr_err=1; then op_load -> wr_err=0.
//  T3: random dma_wr_req_rdy at 30% with 3 back-to-back cmds (last on the 3rd)
//   -> no lost or duplicated packets; payload stable under stall; exactly one wr_done.
//  T4: partial beat (valid atoms-1=1) then full beat, cmd size=5
//   -> atoms sent are b0.a0, b0.a1, b1.a0..a3.
//  T5: reset asserted mid-DATA, then new cmd
//   -> all outputs 0 after reset; new header is the first packet; no stale atoms.
//  T6: cmd size=8191, continuous traffic
//   -> exactly 8192 data atoms, no rem wrap, throughput 1 atom/cycle.

Source files
------------

// File: rtl/autosa_sdp_wdma_pkg.sv
// Shared constants, field offsets and types for the SDP write-DMA egress.
package autosa_sdp_wdma_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned SIZE_W         = 13;
    localparam int unsigned ATOM_W         = 64;
    localparam int unsigned ATOMS_PER_BEAT = 4;
    localparam int unsigned BEAT_W         = ATOMS_PER_BEAT * ATOM_W;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned REM_W          = SIZE_W + 1;
    localparam int unsigned CMD_W          = ADDR_W + SIZE_W + 1;
    localparam int unsigned DP_PD_W        = BEAT_W + IDX_W;
    localparam int unsigned REQ_W          = 66;

    localparam int unsigned CMD_ADDR_LSB = 0;
    localparam int unsigned CMD_SIZE_LSB = 32;
    localparam int unsigned CMD_LAST_BIT = 45;
    localparam int unsigned DP_CNT_LSB   = 256;
    localparam int unsigned REQ_TYPE_BIT = 65;
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_SIZE_LSB = 32;
    localparam int unsigned DATA_LSB     = 0;

    localparam logic PKT_HDR  = 1'b0;
    localparam logic PKT_DATA = 1'b1;

    typedef enum logic [1:0] {StIdle, StHdr, StData} wdma_state_e;

    // done marks the final atom of a cmd_last command
    typedef struct packed {
        logic             done;
        logic [REQ_W-1:0] pd;
    } skid_ent_t;

    function automatic logic [REQ_W-1:0] make_hdr(input logic [ADDR_W-1:0] addr,
                                                  input logic [SIZE_W-1:0] size);
        logic [REQ_W-1:0] pkt;
        pkt = '0;
        pkt[REQ_TYPE_BIT] = PKT_HDR;
        pkt[HDR_ADDR_LSB +: ADDR_W] = addr;
        pkt[HDR_SIZE_LSB +: SIZE_W] = size;
        return pkt;
    endfunction

    function automatic logic [REQ_W-1:0] make_data(input logic [ATOM_W-1:0] atom);
        logic [REQ_W-1:0] pkt;
        pkt = '0;
        pkt[REQ_TYPE_BIT] = PKT_DATA;
        pkt[DATA_LSB +: ATOM_W] = atom;
        return pkt;
    endfunction

endpackage

// File: rtl/autosa_sdp_wdma_eg_if.sv
// Command, datapath-beat and DMA write-request channels of the write egress.
interface autosa_sdp_wdma_eg_if;
    import autosa_sdp_wdma_pkg::*;

    logic [CMD_W-1:0]   cq2eg_pd;
    logic               cq2eg_pvld;
    logic               cq2eg_prdy;
    logic [DP_PD_W-1:0] dp2wdma_pd;
    logic               dp2wdma_valid;
    logic               dp2wdma_ready;
    logic [REQ_W-1:0]   dma_wr_req_pd;
    logic               dma_wr_req_vld;
    logic               dma_wr_req_rdy;

    modport master (
        output cq2eg_pd, cq2eg_pvld, dp2wdma_pd, dp2wdma_valid, dma_wr_req_rdy,
        input  cq2eg_prdy, dp2wdma_ready, dma_wr_req_pd, dma_wr_req_vld
    );

    modport slave (
        input  cq2eg_pd, cq2eg_pvld, dp2wdma_pd, dp2wdma_valid, dma_wr_req_rdy,
        output cq2eg_prdy, dp2wdma_ready, dma_wr_req_pd, dma_wr_req_vld
    );

endinterface

// File: rtl/autosa_sdp_wdma_eg_unpack.sv
// Holds one datapath beat and hands out its atoms one per pop, atom0 first.
module autosa_sdp_wdma_eg_unpack
    import autosa_sdp_wdma_pkg::*;
(
    input  logic              autosa_core_clk,
    input  logic              autosa_core_rst,
    input  logic              i_load,
    input  logic [BEAT_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_cnt,
    input  logic              i_pop,
    input  logic              i_drop,
    output logic              o_valid,
    output logic [ATOM_W-1:0] o_atom,
    output logic              o_last
);

    logic [ATOMS_PER_BEAT-1:0][ATOM_W-1:0] r_data;
    logic [IDX_W-1:0]                      r_cnt;
    logic [IDX_W-1:0]                      r_idx;
    logic                                  r_valid;

    // A load wins over a pop: the final atom leaves as the next beat arrives
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_cnt   <= i_cnt;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (i_pop) begin
            if (o_last || i_drop) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_atom  = r_data[r_idx];
    assign o_last  = r_valid && (r_idx == r_cnt);

endmodule

// File: rtl/autosa_sdp_wdma_eg.sv
// Write-side DMA egress: per command one header packet then its data atoms,
// through a 2-entry skid stage, with layer-done pulse and sticky overrun status.
module autosa_sdp_wdma_eg
    import autosa_sdp_wdma_pkg::*;
(
    input  logic                 autosa_core_clk,
    input  logic                 autosa_core_rst,
    input  logic                 op_load,
    autosa_sdp_wdma_eg_if.slave  bus,
    output logic                 wr_done,
    output logic                 dp2reg_status_wr_err
);

    wdma_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_rem;
    logic              r_last;
    skid_ent_t         r_ent0, r_ent1, w_ent0_nxt, w_ent1_nxt, w_push_ent;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic              r_wr_done, r_wr_err;

    logic              w_prdy, w_dready, w_push, w_pop, w_can_push;
    logic              w_cmd_acc, w_beat_acc, w_rem_dec, w_err_set;
    logic              w_u_pop, w_u_drop, w_u_valid, w_u_last;
    logic [ATOM_W-1:0] w_u_atom;
    logic [SIZE_W-1:0] w_hdr_size;

    autosa_sdp_wdma_eg_unpack u_unpack (
        .autosa_core_clk (autosa_core_clk),
        .autosa_core_rst (autosa_core_rst),
        .i_load          (w_beat_acc),
        .i_data          (bus.dp2wdma_pd[0 +: BEAT_W]),
        .i_cnt           (bus.dp2wdma_pd[DP_CNT_LSB +: IDX_W]),
        .i_pop           (w_u_pop),
        .i_drop          (w_u_drop),
        .o_valid         (w_u_valid),
        .o_atom          (w_u_atom),
        .o_last          (w_u_last)
    );

    // Push gating uses only the registered fill level, never dma_wr_req_rdy
    assign w_can_push = (r_cnt != 2'd2);
    assign w_hdr_size = SIZE_W'(r_rem - REM_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_prdy      = 1'b0;
        w_dready    = 1'b0;
        w_push      = 1'b0;
        w_push_ent  = '0;
        w_u_pop     = 1'b0;
        w_u_drop    = 1'b0;
        w_rem_dec   = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_prdy = 1'b1;
                if (bus.cq2eg_pvld) begin
                    w_state_nxt = StHdr;
                end
            end
            StHdr: begin
                if (w_can_push) begin
                    w_push        = 1'b1;
                    w_push_ent.pd = make_hdr(r_addr, w_hdr_size);
                    w_state_nxt   = StData;
                end
            end
            StData: begin
                if (w_can_push && w_u_valid) begin
                    w_push          = 1'b1;
                    w_push_ent.pd   = make_data(w_u_atom);
                    w_push_ent.done = r_last && (r_rem == REM_W'(1));
                    w_u_pop         = 1'b1;
                    w_rem_dec       = 1'b1;
                    if (r_rem == REM_W'(1)) begin
                        w_state_nxt = StIdle;
                        // Leftover atoms of this beat belong to no command
                        if (!w_u_last) begin
                            w_u_drop  = 1'b1;
                            w_err_set = 1'b1;
                        end
                    end
                end
                w_dready = w_can_push && (!w_u_valid || (w_u_last && (r_rem != REM_W'(1))));
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.cq2eg_prdy     = w_prdy & ~autosa_core_rst;
    assign bus.dp2wdma_ready  = w_dready & ~autosa_core_rst;
    assign bus.dma_wr_req_vld = (r_cnt != 2'd0) & ~autosa_core_rst;
    assign bus.dma_wr_req_pd  = r_ent0.pd;

    assign w_cmd_acc  = bus.cq2eg_pvld & bus.cq2eg_prdy;
    assign w_beat_acc = bus.dp2wdma_valid & bus.dp2wdma_ready;
    assign w_pop      = bus.dma_wr_req_vld & bus.dma_wr_req_rdy;

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_acc) begin
                r_addr <= bus.cq2eg_pd[CMD_ADDR_LSB +: ADDR_W];
                r_rem  <= {1'b0, bus.cq2eg_pd[CMD_SIZE_LSB +: SIZE_W]} + REM_W'(1);
                r_last <= bus.cq2eg_pd[CMD_LAST_BIT];
            end else if (w_rem_dec) begin
                r_rem <= r_rem - REM_W'(1);
            end
        end
    end

    // Push and pop together only happen with one entry held
    always_comb begin
        w_ent0_nxt = r_ent0;
        w_ent1_nxt = r_ent1;
        w_cnt_nxt  = r_cnt;
        unique case ({w_push, w_pop})
            2'b10: begin
                if (r_cnt == 2'd0) begin
                    w_ent0_nxt = w_push_ent;
                end else begin
                    w_ent1_nxt = w_push_ent;
                end
                w_cnt_nxt = r_cnt + 2'd1;
            end
            2'b01: begin
                w_ent0_nxt = r_ent1;
                w_cnt_nxt  = r_cnt - 2'd1;
            end
            2'b11: w_ent0_nxt = w_push_ent;
            default: ;
        endcase
    end

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            r_ent0    <= '0;
            r_ent1    <= '0;
            r_cnt     <= '0;
            r_wr_done <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_ent0    <= w_ent0_nxt;
            r_ent1    <= w_ent1_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_done <= w_pop & r_ent0.done;
            if (w_err_set) begin
                r_wr_err <= 1'b1;
            end else if (op_load) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    assign wr_done              = r_wr_done;
    assign dp2reg_status_wr_err = r_wr_err;

endmodule

// File: tb/tb_autosa_sdp_wdma_eg.sv
// Directed bench: a packet-list model built from commands and beats, checked every cycle.
module tb_autosa_sdp_wdma_eg;
    import autosa_sdp_wdma_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_load = 1'b0;
    logic wr_done, wr_err;

    always #5 clk = ~clk;

    autosa_sdp_wdma_eg_if bus();

    autosa_sdp_wdma_eg dut (
        .autosa_core_clk      (clk),
        .autosa_core_rst      (rst),
        .op_load              (op_load),
        .bus                  (bus),
        .wr_done              (wr_done),
        .dp2reg_status_wr_err (wr_err)
    );

    int n_err = 0;
    int n_chk = 0;

    logic [CMD_W-1:0]   cmd_q[$];
    logic [DP_PD_W-1:0] beat_q[$];
    logic [REQ_W-1:0]   exp_q[$];
    logic               exp_done_q[$];
    logic [REQ_W-1:0]   log_q[$];
    int                 data_cyc_q[$];

    int m_rem = 0;
    bit m_last = 1'b0;
    bit m_err = 1'b0;
    bit rdy_rand = 1'b0;
    int cyc = 0;
    int done_total = 0;
    int t_log, t_data, t_done;

    function automatic void chk(input string name, input logic [65:0] act,
                                input logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Model: header, then atoms in order until the command's count is used up
    function automatic void m_cmd(input logic [31:0] addr, input int size, input bit last);
        cmd_q.push_back({last, 13'(size), addr});
        exp_q.push_back({2'b00, 19'd0, 13'(size), addr});
        exp_done_q.push_back(1'b0);
        m_rem  = size + 1;
        m_last = last;
    endfunction

    function automatic void m_beat(input logic [63:0] base, input int cnt);
        logic [255:0] d;
        for (int i = 0; i < 4; i++) d[i*64 +: 64] = base + 64'(i);
        beat_q.push_back({2'(cnt), d});
        for (int i = 0; i <= cnt; i++) begin
            if (m_rem > 0) begin
                exp_q.push_back({2'b10, base + 64'(i)});
                exp_done_q.push_back(m_last && (m_rem == 1));
                m_rem--;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    function automatic logic [65:0] pk(input int k);
        return (t_log + k < log_q.size()) ? log_q[t_log + k] : 66'h3_FFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin : cmd_drv
        bit acc;
        bus.cq2eg_pvld = 1'b0;
        bus.cq2eg_pd   = '0;
        forever begin
            @(negedge clk);
            acc = bus.cq2eg_pvld && bus.cq2eg_prdy;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(cmd_q.pop_front());
                bus.cq2eg_pvld = 1'b0;
            end
            if (rst) bus.cq2eg_pvld = 1'b0;
            else if (!bus.cq2eg_pvld && cmd_q.size() != 0) begin
                bus.cq2eg_pd   = cmd_q[0];
                bus.cq2eg_pvld = 1'b1;
            end
        end
    end

    initial begin : beat_drv
        bit acc;
        bus.dp2wdma_valid = 1'b0;
        bus.dp2wdma_pd    = '0;
        forever begin
            @(negedge clk);
            acc = bus.dp2wdma_valid && bus.dp2wdma_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(beat_q.pop_front());
                bus.dp2wdma_valid = 1'b0;
            end
            if (rst) bus.dp2wdma_valid = 1'b0;
            else if (!bus.dp2wdma_valid && beat_q.size() != 0) begin
                bus.dp2wdma_pd    = beat_q[0];
                bus.dp2wdma_valid = 1'b1;
            end
        end
    end

    initial begin : rdy_drv
        bus.dma_wr_req_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.dma_wr_req_rdy = rdy_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    initial begin : mon
        bit acc, pend_done, prev_stall;
        logic [REQ_W-1:0] prev_pd;
        pend_done  = 1'b0;
        prev_stall = 1'b0;
        prev_pd    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend_done  = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            chk("wr_done", wr_done, pend_done);
            if (prev_stall) begin
                chk("stall_vld", bus.dma_wr_req_vld, 1);
                chk("stall_pd", bus.dma_wr_req_pd, prev_pd);
            end
            acc = bus.dma_wr_req_vld && bus.dma_wr_req_rdy;
            pend_done = 1'b0;
            if (acc) begin
                log_q.push_back(bus.dma_wr_req_pd);
                if (bus.dma_wr_req_pd[65]) data_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_pkt: got %h want none", bus.dma_wr_req_pd);
                end else begin
                    chk("pkt", bus.dma_wr_req_pd, exp_q.pop_front());
                    pend_done = exp_done_q.pop_front();
                end
            end
            if (wr_done) done_total++;
            prev_stall = bus.dma_wr_req_vld && !bus.dma_wr_req_rdy;
            prev_pd    = bus.dma_wr_req_pd;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        cmd_q.delete();
        beat_q.delete();
        exp_q.delete();
        exp_done_q.delete();
        m_rem = 0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", bus.dma_wr_req_vld, 0);
        chk("rst_pd", bus.dma_wr_req_pd, 0);
        chk("rst_prdy", bus.cq2eg_prdy, 0);
        chk("rst_dready", bus.dp2wdma_ready, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_err", wr_err, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic start_test();
        t_log  = log_q.size();
        t_data = data_cyc_q.size();
        t_done = done_total;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0 || beat_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d pkts left, want 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: sim time %0t, want finish earlier", $time);
        $fatal(1);
    end

    initial begin : main
        int n;
        do_reset();

        // T1: 8 atoms over two full beats
        start_test();
        m_cmd(32'h1000, 7, 1'b1);
        m_beat(64'hD100_0000_0000_0000, 3);
        m_beat(64'hD100_0000_0000_0004, 3);
        wait_drain(200);
        chk("t1_npkt", log_q.size() - t_log, 9);
        chk("t1_hdr", pk(0), 66'h0_0000_0007_0000_1000);
        chk("t1_a0", pk(1), 66'h2_D100_0000_0000_0000);
        chk("t1_a7", pk(8), 66'h2_D100_0000_0000_0007);
        chk("t1_done", done_total - t_done, 1);
        chk("t1_err", wr_err, 0);

        // T2: beat overruns the command, then op_load clears status
        start_test();
        m_cmd(32'h2000, 2, 1'b1);
        m_beat(64'hB200_0000_0000_0000, 3);
        wait_drain(200);
        chk("t2_npkt", log_q.size() - t_log, 4);
        chk("t2_a2", pk(3), 66'h2_B200_0000_0000_0002);
        chk("t2_err", wr_err, 1);
        chk("t2_err_model", wr_err, m_err);
        chk("t2_done", done_total - t_done, 1);
        @(posedge clk);
        #1;
        op_load = 1'b1;
        @(posedge clk);
        #1;
        op_load = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        chk("t2_clr", wr_err, 0);

        // T3: three back-to-back commands under random backpressure
        rdy_rand = 1'b1;
        start_test();
        m_cmd(32'h3000, 3, 1'b0);
        m_beat(64'hC300_0000_0000_0000, 3);
        m_cmd(32'h3100, 1, 1'b0);
        m_beat(64'hC310_0000_0000_0000, 1);
        m_cmd(32'h3200, 5, 1'b1);
        m_beat(64'hC320_0000_0000_0000, 3);
        m_beat(64'hC324_0000_0000_0000, 1);
        wait_drain(1000);
        chk("t3_npkt", log_q.size() - t_log, 15);
        chk("t3_done", done_total - t_done, 1);
        chk("t3_err", wr_err, 0);
        rdy_rand = 1'b0;

        // T4: partial beat followed by a full beat
        start_test();
        m_cmd(32'h4000, 5, 1'b1);
        m_beat(64'hE400_0000_0000_0000, 1);
        m_beat(64'hE410_0000_0000_0000, 3);
        wait_drain(200);
        chk("t4_npkt", log_q.size() - t_log, 7);
        chk("t4_b0a1", pk(2), 66'h2_E400_0000_0000_0001);
        chk("t4_b1a0", pk(3), 66'h2_E410_0000_0000_0000);
        chk("t4_b1a3", pk(6), 66'h2_E410_0000_0000_0003);
        chk("t4_err", wr_err, 0);

        // T5: reset in the middle of a data run, then a fresh command
        start_test();
        m_cmd(32'h5000, 15, 1'b1);
        for (int b = 0; b < 4; b++) m_beat(64'hF500_0000_0000_0000 + 64'(b * 4), 3);
        n = 0;
        while (data_cyc_q.size() - t_data < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("t5_started", n < 200, 1);
        do_reset();
        start_test();
        m_cmd(32'h5100, 1, 1'b1);
        m_beat(64'hF510_0000_0000_0000, 1);
        wait_drain(200);
        chk("t5_npkt", log_q.size() - t_log, 3);
        chk("t5_hdr", pk(0), 66'h0_0000_0001_0000_5100);
        chk("t5_a1", pk(2), 66'h2_F510_0000_0000_0001);
        chk("t5_done", done_total - t_done, 1);

        // T6: maximum-size command streamed at full rate
        start_test();
        m_cmd(32'h6000, 8191, 1'b1);
        for (int b = 0; b < 2048; b++) m_beat(64'h6000_0000_0000_0000 + 64'(b * 4), 3);
        wait_drain(20000);
        chk("t6_ndata", data_cyc_q.size() - t_data, 8192);
        chk("t6_npkt", log_q.size() - t_log, 8193);
        if (data_cyc_q.size() - t_data == 8192)
            chk("t6_rate", data_cyc_q[data_cyc_q.size() - 1] - data_cyc_q[t_data], 8191);
        else
            chk("t6_rate_nodata", data_cyc_q.size() - t_data, 8192);
        chk("t6_hdr", pk(0), 66'h0_0000_1FFF_0000_6000);
        chk("t6_done", done_total - t_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
